branch_resolve_unit: RTL and testbench
======================================

// Module: branch_resolve_unit
// PURPOSE
//  Parametrised branch predict/resolve block for the pipelined core.
//  Keeps a table of 2-bit saturating counters (BHT) that gives the IF stage a taken/not-taken
//  prediction, evaluates J/JR/BEQ/BNE/BGEZ in EX, and issues a registered redirect+flush on
//  mispredict. Sits between the control decode and the PC-select logic; also keeps statistics counters.
// PARAMETERS
//  ADDR_W    32     width of PC, targets and register operands
//  IDX_W     6      BHT index bits; table has 2**IDX_W entries, index = pc[IDX_W+1:2]
//  CTR_INIT  2'b01  counter value after reset (weakly not-taken)
//  CNT_W     16     width of statistics counters
// PORTS
//  in_clk             in   1       clock, all state on rising edge
//  in_rst             in   1       reset, asynchronous, active-high
//  in_if_pc           in   ADDR_W  fetch PC
//  out_pred_taken     out  1       combinational: BHT[idx(in_if_pc)][1]
//  in_ex_valid        in   1       EX holds a valid instruction this cycle
//  in_ex_kind         in   3       0 none,1 J,2 JR,3 BEQ,4 BNE,5 BGEZ,6-7 treated as none
//  in_ex_pc           in   ADDR_W  PC of EX instruction (BHT update index)
//  in_ex_pred_taken   in   1       prediction carried down from IF
//  in_ex_rs           in   ADDR_W  rs operand (JR target, compare, BGEZ sign)
//  in_ex_rt           in   ADDR_W  rt operand
//  in_ex_target       in   ADDR_W  decoded J/branch target
//  in_ex_fallthru     in   ADDR_W  in_ex_pc+4
//  in_stat_clr        in   1       synchronous clear of statistics
//  out_redirect       out  1       one-cycle pulse: load out_redirect_pc, flush IF/ID
//  out_redirect_pc    out  ADDR_W  corrected PC, valid while out_redirect=1
//  out_branch_cnt     out  CNT_W   resolved control-transfer count, saturating
//  out_mispred_cnt    out  CNT_W   redirect count, saturating
// BEHAVIOUR
//  Reset (async): all BHT entries=CTR_INIT; out_redirect=0; out_redirect_pc=0; both counters=0;
//   FSM=RUN. Reset mid-redirect drops the pending pulse.
//  Resolve (kind 1..5 and in_ex_valid and FSM=RUN): taken = J|JR ->1; BEQ rs==rt; BNE rs!=rt;
//   BGEZ ~rs[ADDR_W-1] (signed). dest = JR ? rs : (taken ? in_ex_target : in_ex_fallthru).
//  Mispredict = (taken != in_ex_pred_taken) | (kind==JR). JR always redirects; its target is not predicted.
//  Latency: on mispredict at edge N, out_redirect=1 and out_redirect_pc=dest during cycle N+1 only.
//  FSM: RUN -> SHADOW on mispredict edge; SHADOW -> RUN unconditionally next edge.
//   In SHADOW the EX instruction is wrong-path: no BHT update, no counter change, no redirect.
//   Back-to-back redirects therefore never occur; min spacing 2 cycles.
//  BHT update only for BEQ/BNE/BGEZ resolves in RUN: taken -> ctr+1 sat at 3, else ctr-1 sat at 0.
//   J/JR never touch BHT. Same-cycle read/write of one index: out_pred_taken shows the old value
//   (no bypass); new value visible the following cycle.
//  Counters: out_branch_cnt +1 per resolve in RUN; out_mispred_cnt +1 per mispredict; saturate at
//   all-ones, no wrap. in_stat_clr wins over simultaneous increment (result 0).
//  kind 0/6/7 or in_ex_valid=0: no action. Index uses pc bits only; aliasing is permitted.
// TESTING
//  Reset, read idx 0..63 -> out_pred_taken=0 (CTR_INIT=01); counters 0; out_redirect=0.
//  BEQ pc=0x40, rs=rt=5, pred 0, target 0x80 -> next cycle redirect=1, pc=0x80; mispred_cnt=1;
//   BHT[16]=10 so pred for 0x40 becomes 1.
//  Three taken BEQ at 0x40 then one not-taken, pred per table -> ctr 01->10->11->11->10;
//   mispredicts only on 1st and 4th.
//  JR rs=0x1234 pred 1 -> redirect pc=0x1234; BHT unchanged; wrong-path BNE in SHADOW ignored
//   (cnt unchanged, no pulse).
//  BGEZ rs=0x80000000 pred 0 -> no redirect, ctr decrements saturating at 00; BGEZ rs=0 pred 0
//   -> redirect to target.
//  Preload counters to 0xFFFF -> stay 0xFFFF on more branches; stat_clr with branch -> 0;
//   async rst during redirect pulse -> redirect=0 immediately.

Source files
------------

// File: rtl/branch_resolve_unit.sv
// Branch predict/resolve: BHT of 2-bit saturating counters for IF, EX-stage resolution of
// J/JR/BEQ/BNE/BGEZ with a registered redirect pulse, plus saturating statistics counters.
module branch_resolve_unit #(
  parameter int          ADDR_W   = 32,
  parameter int          IDX_W    = 6,
  parameter logic [1:0]  CTR_INIT = 2'b01,
  parameter int          CNT_W    = 16
) (
  input  logic              in_clk,
  input  logic              in_rst,
  input  logic [ADDR_W-1:0] in_if_pc,
  output logic              out_pred_taken,
  input  logic              in_ex_valid,
  input  logic [2:0]        in_ex_kind,
  input  logic [ADDR_W-1:0] in_ex_pc,
  input  logic              in_ex_pred_taken,
  input  logic [ADDR_W-1:0] in_ex_rs,
  input  logic [ADDR_W-1:0] in_ex_rt,
  input  logic [ADDR_W-1:0] in_ex_target,
  input  logic [ADDR_W-1:0] in_ex_fallthru,
  input  logic              in_stat_clr,
  output logic              out_redirect,
  output logic [ADDR_W-1:0] out_redirect_pc,
  output logic [CNT_W-1:0]  out_branch_cnt,
  output logic [CNT_W-1:0]  out_mispred_cnt
);

  // state   | meaning
  // RUN     | EX instruction is on the correct path; resolve normally
  // SHADOW  | cycle after a redirect; EX holds a wrong-path instruction, ignore it
  typedef enum logic {ST_RUN, ST_SHADOW} state_t;

  localparam int ENTRIES = 2 ** IDX_W;
  localparam logic [2:0] K_J = 3'd1, K_JR = 3'd2, K_BEQ = 3'd3, K_BNE = 3'd4, K_BGEZ = 3'd5;

  state_t            state_q, state_d;
  logic [1:0]        bht [ENTRIES];
  logic [IDX_W-1:0]  if_idx, ex_idx;
  logic              is_ctl, is_cond, is_jr, taken, resolve, mispred, bht_we;
  logic [ADDR_W-1:0] dest;
  logic [1:0]        ctr_old, ctr_new;
  logic              unused_pc_bits;

  assign if_idx         = in_if_pc[IDX_W+1:2];
  assign ex_idx         = in_ex_pc[IDX_W+1:2];
  assign out_pred_taken = bht[if_idx][1];
  assign unused_pc_bits = ^{in_if_pc[ADDR_W-1:IDX_W+2], in_if_pc[1:0],
                            in_ex_pc[ADDR_W-1:IDX_W+2], in_ex_pc[1:0]};

  always_comb begin
    is_ctl  = 1'b0;
    is_cond = 1'b0;
    is_jr   = 1'b0;
    taken   = 1'b0;
    case (in_ex_kind)
      K_J:    begin is_ctl = 1'b1; taken = 1'b1; end
      K_JR:   begin is_ctl = 1'b1; taken = 1'b1; is_jr = 1'b1; end
      K_BEQ:  begin is_ctl = 1'b1; is_cond = 1'b1; taken = (in_ex_rs == in_ex_rt); end
      K_BNE:  begin is_ctl = 1'b1; is_cond = 1'b1; taken = (in_ex_rs != in_ex_rt); end
      K_BGEZ: begin is_ctl = 1'b1; is_cond = 1'b1; taken = ~in_ex_rs[ADDR_W-1]; end
      default: ;
    endcase

    resolve = in_ex_valid & is_ctl & (state_q == ST_RUN);
    mispred = resolve & ((taken != in_ex_pred_taken) | is_jr);
    bht_we  = resolve & is_cond;
    dest    = is_jr ? in_ex_rs : (taken ? in_ex_target : in_ex_fallthru);

    ctr_old = bht[ex_idx];
    ctr_new = ctr_old;
    if (taken && ctr_old != 2'b11)       ctr_new = ctr_old + 2'b01;
    else if (!taken && ctr_old != 2'b00) ctr_new = ctr_old - 2'b01;

    state_d = state_q;
    case (state_q)
      ST_RUN:    if (mispred) state_d = ST_SHADOW;
      ST_SHADOW: state_d = ST_RUN;
      default:   state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge in_clk or posedge in_rst) begin
    if (in_rst) state_q <= ST_RUN;
    else        state_q <= state_d;
  end

  // No read bypass: IF sees the written value only from the next cycle on.
  always_ff @(posedge in_clk or posedge in_rst) begin
    if (in_rst) begin
      for (int i = 0; i < ENTRIES; i++) bht[i] <= CTR_INIT;
    end else if (bht_we) begin
      bht[ex_idx] <= ctr_new;
    end
  end

  always_ff @(posedge in_clk or posedge in_rst) begin
    if (in_rst) begin
      out_redirect    <= 1'b0;
      out_redirect_pc <= '0;
    end else begin
      out_redirect <= mispred;
      if (mispred) out_redirect_pc <= dest;
    end
  end

  always_ff @(posedge in_clk or posedge in_rst) begin
    if (in_rst) begin
      out_branch_cnt  <= '0;
      out_mispred_cnt <= '0;
    end else if (in_stat_clr) begin
      out_branch_cnt  <= '0;
      out_mispred_cnt <= '0;
    end else begin
      if (resolve && out_branch_cnt != '1)  out_branch_cnt  <= out_branch_cnt + 1'b1;
      if (mispred && out_mispred_cnt != '1) out_mispred_cnt <= out_mispred_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed bench for branch_resolve_unit: expected redirect PCs go into a scoreboard queue
// that a negedge monitor drains; BHT predictions and counters are checked inline.
module tb_branch_resolve_unit;
  localparam int ADDR_W = 32;
  localparam int CNT_W  = 8;

  logic              in_clk = 1'b0;
  logic              in_rst;
  logic [ADDR_W-1:0] in_if_pc;
  logic              out_pred_taken;
  logic              in_ex_valid;
  logic [2:0]        in_ex_kind;
  logic [ADDR_W-1:0] in_ex_pc, in_ex_rs, in_ex_rt, in_ex_target, in_ex_fallthru;
  logic              in_ex_pred_taken;
  logic              in_stat_clr;
  logic              out_redirect;
  logic [ADDR_W-1:0] out_redirect_pc;
  logic [CNT_W-1:0]  out_branch_cnt, out_mispred_cnt;

  int checks = 0;
  int failures = 0;
  logic [ADDR_W-1:0] exp_q [$];

  branch_resolve_unit #(.ADDR_W(ADDR_W), .IDX_W(6), .CTR_INIT(2'b01), .CNT_W(CNT_W)) dut (
    .in_clk(in_clk), .in_rst(in_rst), .in_if_pc(in_if_pc), .out_pred_taken(out_pred_taken),
    .in_ex_valid(in_ex_valid), .in_ex_kind(in_ex_kind), .in_ex_pc(in_ex_pc),
    .in_ex_pred_taken(in_ex_pred_taken), .in_ex_rs(in_ex_rs), .in_ex_rt(in_ex_rt),
    .in_ex_target(in_ex_target), .in_ex_fallthru(in_ex_fallthru), .in_stat_clr(in_stat_clr),
    .out_redirect(out_redirect), .out_redirect_pc(out_redirect_pc),
    .out_branch_cnt(out_branch_cnt), .out_mispred_cnt(out_mispred_cnt)
  );

  always #5 in_clk = ~in_clk;

  task automatic chk(input string name, input logic [ADDR_W-1:0] act, input logic [ADDR_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every redirect pulse must match the oldest queued expectation.
  always @(negedge in_clk) begin
    if (!in_rst && out_redirect) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_redirect: got pc 0x%0h expected no pulse", out_redirect_pc);
      end else begin
        logic [ADDR_W-1:0] e;
        e = exp_q.pop_front();
        if (out_redirect_pc !== e) begin
          failures++;
          $display("FAIL redirect_pc: got 0x%0h expected 0x%0h", out_redirect_pc, e);
        end
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin @(posedge in_clk); #1; end
  endtask

  task automatic issue(input logic [2:0] kind, input logic [ADDR_W-1:0] pc, input logic pred,
                       input logic [ADDR_W-1:0] rs, input logic [ADDR_W-1:0] rt,
                       input logic [ADDR_W-1:0] target, input logic exp_redir,
                       input logic [ADDR_W-1:0] exp_pc);
    in_ex_valid      = 1'b1;
    in_ex_kind       = kind;
    in_ex_pc         = pc;
    in_ex_pred_taken = pred;
    in_ex_rs         = rs;
    in_ex_rt         = rt;
    in_ex_target     = target;
    in_ex_fallthru   = pc + 32'd4;
    if (exp_redir) exp_q.push_back(exp_pc);
    @(posedge in_clk); #1;
    in_ex_valid = 1'b0;
  endtask

  task automatic chk_pred(input string name, input logic [ADDR_W-1:0] pc, input logic exp);
    in_if_pc = pc;
    #1;
    chk(name, {31'd0, out_pred_taken}, {31'd0, exp});
  endtask

  task automatic chk_cnt(input string name, input int br, input int mp);
    chk({name, "_branch_cnt"}, {24'd0, out_branch_cnt}, br);
    chk({name, "_mispred_cnt"}, {24'd0, out_mispred_cnt}, mp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    in_rst = 1'b1; in_if_pc = '0; in_ex_valid = 1'b0; in_ex_kind = '0; in_ex_pc = '0;
    in_ex_pred_taken = 1'b0; in_ex_rs = '0; in_ex_rt = '0; in_ex_target = '0;
    in_ex_fallthru = '0; in_stat_clr = 1'b0;
    idle(2);
    in_rst = 1'b0;
    idle(1);

    for (int i = 0; i < 64; i++) chk_pred("reset_pred", i * 4, 1'b0);
    chk_cnt("reset", 0, 0);
    chk("reset_redirect", {31'd0, out_redirect}, 32'd0);

    // BEQ taken, predicted not-taken: 01 -> 10
    issue(3'd3, 32'h40, 1'b0, 32'd5, 32'd5, 32'h80, 1'b1, 32'h80);
    chk_cnt("beq1", 1, 1);
    chk_pred("beq1_pred", 32'h40, 1'b1);
    idle(1);
    issue(3'd3, 32'h40, 1'b1, 32'd5, 32'd5, 32'h80, 1'b0, 32'h0);   // 10 -> 11
    chk_pred("beq2_pred", 32'h40, 1'b1);
    issue(3'd3, 32'h40, 1'b1, 32'd5, 32'd5, 32'h80, 1'b0, 32'h0);   // 11 -> 11
    issue(3'd3, 32'h40, 1'b1, 32'd5, 32'd6, 32'h80, 1'b1, 32'h44);  // not taken: 11 -> 10
    chk_cnt("beq4", 4, 2);
    chk_pred("beq4_pred", 32'h40, 1'b1);
    idle(1);

    // JR then a wrong-path BNE in SHADOW that would otherwise mispredict and train BHT
    issue(3'd2, 32'h40, 1'b1, 32'h1234, 32'd0, 32'h0, 1'b1, 32'h1234);
    chk_cnt("jr", 5, 3);
    issue(3'd4, 32'h40, 1'b1, 32'd3, 32'd3, 32'h90, 1'b0, 32'h0);
    chk_cnt("shadow", 5, 3);
    chk_pred("shadow_pred", 32'h40, 1'b1);

    // BGEZ at idx 0: 01 -> 00 -> 00 -> 01 -> 10
    issue(3'd5, 32'h100, 1'b0, 32'h80000000, 32'd0, 32'h200, 1'b0, 32'h0);
    issue(3'd5, 32'h100, 1'b0, 32'h80000000, 32'd0, 32'h200, 1'b0, 32'h0);
    issue(3'd5, 32'h100, 1'b0, 32'd0, 32'd0, 32'h200, 1'b1, 32'h200);
    chk_pred("bgez_sat_pred", 32'h100, 1'b0);
    idle(1);
    in_if_pc = 32'h100;
    #1 chk("no_bypass_pred", {31'd0, out_pred_taken}, 32'd0);
    issue(3'd5, 32'h100, 1'b0, 32'd0, 32'd0, 32'h200, 1'b1, 32'h200);
    chk_pred("bgez_inc_pred", 32'h100, 1'b1);
    chk_cnt("bgez", 9, 5);
    idle(1);

    // J predicted taken, undefined kind, and invalid slot
    issue(3'd1, 32'h80, 1'b1, 32'd0, 32'd0, 32'h300, 1'b0, 32'h0);
    chk_pred("j_no_bht", 32'h80, 1'b0);
    issue(3'd6, 32'h80, 1'b0, 32'd1, 32'd1, 32'h300, 1'b0, 32'h0);
    in_ex_valid = 1'b0; in_ex_kind = 3'd2;
    idle(1);
    chk_cnt("j_none", 10, 5);

    // Saturation of both counters (CNT_W=8)
    for (int i = 0; i < 255; i++) begin
      issue(3'd2, 32'h0, 1'b1, 32'h500 + i * 4, 32'd0, 32'h0, 1'b1, 32'h500 + i * 4);
      idle(1);
    end
    chk_cnt("sat", 255, 255);
    issue(3'd2, 32'h0, 1'b1, 32'h900, 32'd0, 32'h0, 1'b1, 32'h900);
    idle(1);
    chk_cnt("sat_hold", 255, 255);

    // Clear wins over a simultaneous increment
    in_stat_clr = 1'b1;
    issue(3'd3, 32'h8, 1'b0, 32'd1, 32'd1, 32'h40, 1'b1, 32'h40);
    in_stat_clr = 1'b0;
    chk_cnt("clr", 0, 0);
    idle(1);
    issue(3'd1, 32'h8, 1'b1, 32'd0, 32'd0, 32'h40, 1'b0, 32'h0);
    chk_cnt("after_clr", 1, 0);

    // Async reset during a redirect pulse drops it at once
    issue(3'd2, 32'h0, 1'b0, 32'h777, 32'd0, 32'h0, 1'b0, 32'h0);
    chk("pulse_before_rst", {31'd0, out_redirect}, 32'd1);
    #1 in_rst = 1'b1;
    #1 chk("pulse_after_rst", {31'd0, out_redirect}, 32'd0);
    chk("pc_after_rst", out_redirect_pc, 32'd0);
    idle(1);
    in_rst = 1'b0;
    chk_cnt("rst2", 0, 0);
    chk_pred("rst2_pred", 32'h100, 1'b0);
    idle(2);

    chk("scoreboard_empty", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
